game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
- Top-level game sequencer for the space invaders design.
- Tracks game phase, lives, level and score from hit/kill pulses produced by the hit detection unit.
- Drives enable and restart strobes to the player, monsters and missiles units.
- Sits between the hit detection, keyboard interface and object units; the video unit reads its phase code to select banners.

Parameters:
- START_KEY, 9'h05A, keyboard keyCode that starts or restarts a game (Enter).
- INIT_LIVES, 3, lives at game start (1..7).
- MAX_LEVEL, 4, number of levels; clearing level MAX_LEVEL wins the game.
- KILLS_PER_LEVEL, 16, monster kills needed to clear a level (1..255).
- POINTS_PER_KILL, 10, score increment per kill.
- INTRO_FRAMES, 120, frames spent in LEVEL_INTRO.
- RESPAWN_FRAMES, 90, frames spent in PLAYER_DIED.
- CLEAR_FRAMES, 120, frames spent in LEVEL_CLEAR.
- SCORE_WIDTH, 16, score width.

Ports:
- clk, input, 1, system clock (divided clock).
- resetN, input, 1, asynchronous active-low reset.
- startOfFrame, input, 1, one-cycle pulse per video frame.
- keyCode, input, 9, current keyboard code.
- make, input, 1, key-press pulse qualifying keyCode.
- player_hit, input, 1, one-cycle pulse: player struck.
- monster_killed, input, 1, one-cycle pulse: one monster destroyed.
- game_phase, output, 3, 0 IDLE, 1 LEVEL_INTRO, 2 PLAYING, 3 PLAYER_DIED, 4 LEVEL_CLEAR, 5 GAME_OVER, 6 GAME_WON.
- game_active, output, 1, high only in PLAYING; gates movement and firing.
- level_start, output, 1, one-cycle pulse; objects reload level layout.
- player_respawn, output, 1, one-cycle pulse; player returns to start position.
- level, output, 4, current level, 1-based.
- lives, output, 3, remaining lives.
- score, output, SCORE_WIDTH, accumulated score.

Behaviour:
- Reset values:
  - game_phase = IDLE; game_active = 0; level_start = 0; player_respawn = 0.
  - level = 1; lives = INIT_LIVES; score = 0.
  - Internal kill_cnt = 0; frame_cnt = 0.
- All outputs are registered; pulses are exactly one clk wide.
- Start condition: make=1 with keyCode==START_KEY in the same cycle. In any other state it is ignored.
- frame_cnt clears on every state entry and increments on startOfFrame. A timed state exits on the clock edge where startOfFrame=1 and frame_cnt==N-1.
- IDLE:
  - On start condition: level = 1, lives = INIT_LIVES, score = 0, kill_cnt = 0.
  - Go to LEVEL_INTRO; level_start pulses in the same cycle as the state change.
- LEVEL_INTRO -> PLAYING after INTRO_FRAMES frames. Hit and kill inputs are ignored outside PLAYING.
- PLAYING, monster_killed:
  - kill_cnt += 1.
  - score += POINTS_PER_KILL, saturating at all-ones (no wrap).
- PLAYING, kill_cnt reaching KILLS_PER_LEVEL with no player_hit that cycle -> LEVEL_CLEAR.
- PLAYING, player_hit:
  - lives -= 1 (never below 0).
  - New lives == 0 -> GAME_OVER.
  - Otherwise -> PLAYER_DIED.
- Simultaneous hit and kill in PLAYING:
  - The kill is counted and scored.
  - The hit takes priority for the state transition.
- PLAYER_DIED, after RESPAWN_FRAMES frames:
  - kill_cnt == KILLS_PER_LEVEL -> LEVEL_CLEAR.
  - Otherwise -> PLAYING, with player_respawn pulsed on the transition edge.
- LEVEL_CLEAR, after CLEAR_FRAMES frames:
  - level == MAX_LEVEL -> GAME_WON.
  - Otherwise level += 1, kill_cnt = 0, -> LEVEL_INTRO with level_start pulse.
- GAME_OVER / GAME_WON: hold score, lives and level. On start condition, behave as from IDLE.
- startOfFrame arriving in the same cycle as a state entry is not counted toward the new state.
- Asynchronous reset mid-state forces all reset values immediately. No pulse is emitted on reset release.
- Illegal game_phase encodings (7) recover to IDLE on the next clock.

Test Plan:
- Reset, then make with keyCode 0x05A -> level_start is one pulse; game_phase=1, level=1, lives=3, score=0. After 120 startOfFrame pulses, game_phase=2 and game_active=1.
- In PLAYING, 16 monster_killed pulses -> score=160; game_phase=4 on the 16th. After 120 frames, level=2, game_phase=1, one level_start pulse.
- In PLAYING, player_hit -> lives=2, game_phase=3, game_active=0. After 90 frames, player_respawn is one pulse and game_phase=2. Three total hits -> game_phase=5, lives=0.
- Kill counter at 15; player_hit and monster_killed in the same cycle -> score +10, lives -1, game_phase=3. After 90 frames, game_phase=4 and no player_respawn pulse.
- Clear 4 levels -> game_phase=6 with score=640. Then START_KEY -> score=0, level=1, lives=3, game_phase=1. A non-start key (0x029) in IDLE -> no change.
- Assert resetN low mid-PLAYING with score=50 -> all outputs return to reset values asynchronously. player_hit/monster_killed in IDLE or LEVEL_INTRO -> no effect.

Source files
------------

// File: rtl/game_flow_controller_if.sv
// Signal bundle between the game sequencer and its neighbours.
// The master drives the stimulus inputs; the slave is the sequencer.
interface game_flow_controller_if #(
    parameter int unsigned SCORE_WIDTH = 16
);
    logic                   startOfFrame;
    logic [8:0]             keyCode;
    logic                   make;
    logic                   player_hit;
    logic                   monster_killed;
    logic [2:0]             game_phase;
    logic                   game_active;
    logic                   level_start;
    logic                   player_respawn;
    logic [3:0]             level;
    logic [2:0]             lives;
    logic [SCORE_WIDTH-1:0] score;

    modport master (
        output startOfFrame, keyCode, make, player_hit, monster_killed,
        input  game_phase, game_active, level_start, player_respawn,
               level, lives, score
    );

    modport slave (
        input  startOfFrame, keyCode, make, player_hit, monster_killed,
        output game_phase, game_active, level_start, player_respawn,
               level, lives, score
    );
endinterface

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: phase, lives, level and score tracking plus
// level_start / player_respawn strobes for the object units.
module game_flow_controller #(
    parameter logic [8:0]  START_KEY       = 9'h05A,
    parameter int unsigned INIT_LIVES      = 3,
    parameter int unsigned MAX_LEVEL       = 4,
    parameter int unsigned KILLS_PER_LEVEL = 16,
    parameter int unsigned POINTS_PER_KILL = 10,
    parameter int unsigned INTRO_FRAMES    = 120,
    parameter int unsigned RESPAWN_FRAMES  = 90,
    parameter int unsigned CLEAR_FRAMES    = 120,
    parameter int unsigned SCORE_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   resetN,
    game_flow_controller_if.slave  gf
);

    localparam int unsigned MAX_FRAMES =
        (INTRO_FRAMES > RESPAWN_FRAMES)
            ? ((INTRO_FRAMES > CLEAR_FRAMES) ? INTRO_FRAMES : CLEAR_FRAMES)
            : ((RESPAWN_FRAMES > CLEAR_FRAMES) ? RESPAWN_FRAMES : CLEAR_FRAMES);
    localparam int unsigned FRAME_W = $clog2(MAX_FRAMES + 1);
    localparam int unsigned KILL_W  = 8;
    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned LIVES_W = 3;
    localparam int unsigned SUM_W   = SCORE_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LEVEL_INTRO = 3'd1,
        PLAYING     = 3'd2,
        PLAYER_DIED = 3'd3,
        LEVEL_CLEAR = 3'd4,
        GAME_OVER   = 3'd5,
        GAME_WON    = 3'd6
    } phase_e;

    phase_e                   state;
    logic                     game_active_q;
    logic                     level_start_q;
    logic                     player_respawn_q;
    logic [LEVEL_W-1:0]       level_q;
    logic [LIVES_W-1:0]       lives_q;
    logic [SCORE_WIDTH-1:0]   score_q;
    logic [KILL_W-1:0]        kill_cnt;
    logic [FRAME_W-1:0]       frame_cnt;

    logic                     start_c;
    logic [FRAME_W-1:0]       frame_last_c;
    logic                     frame_done_c;
    logic [KILL_W-1:0]        kill_inc_c;
    logic                     kill_reach_c;
    logic [SUM_W-1:0]         score_sum_c;
    logic [SCORE_WIDTH-1:0]   score_next_c;
    logic [LIVES_W-1:0]       lives_dec_c;

    assign start_c = gf.make && (gf.keyCode == START_KEY);

    // Last frame index of the current timed state.
    always_comb begin
        frame_last_c = '0;
        case (state)
            LEVEL_INTRO: frame_last_c = FRAME_W'(INTRO_FRAMES - 1);
            PLAYER_DIED: frame_last_c = FRAME_W'(RESPAWN_FRAMES - 1);
            LEVEL_CLEAR: frame_last_c = FRAME_W'(CLEAR_FRAMES - 1);
            default:     frame_last_c = '0;
        endcase
    end

    assign frame_done_c = gf.startOfFrame && (frame_cnt == frame_last_c);

    // Kill counting and saturating score add.
    assign kill_inc_c   = kill_cnt + KILL_W'(1);
    assign kill_reach_c = gf.monster_killed && (kill_inc_c >= KILL_W'(KILLS_PER_LEVEL));
    assign score_sum_c  = {1'b0, score_q} + SUM_W'(POINTS_PER_KILL);
    assign score_next_c = score_sum_c[SCORE_WIDTH] ? '1 : score_sum_c[SCORE_WIDTH-1:0];
    assign lives_dec_c  = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);

    // Game sequencer with registered outputs; strobes default low each cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            game_active_q    <= 1'b0;
            level_start_q    <= 1'b0;
            player_respawn_q <= 1'b0;
            level_q          <= LEVEL_W'(1);
            lives_q          <= LIVES_W'(INIT_LIVES);
            score_q          <= '0;
            kill_cnt         <= '0;
            frame_cnt        <= '0;
        end else begin
            level_start_q    <= 1'b0;
            player_respawn_q <= 1'b0;
            if (gf.startOfFrame) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end

            case (state)
                IDLE, GAME_OVER, GAME_WON: begin
                    if (start_c) begin
                        level_q       <= LEVEL_W'(1);
                        lives_q       <= LIVES_W'(INIT_LIVES);
                        score_q       <= '0;
                        kill_cnt      <= '0;
                        state         <= LEVEL_INTRO;
                        frame_cnt     <= '0;
                        game_active_q <= 1'b0;
                        level_start_q <= 1'b1;
                    end
                end

                LEVEL_INTRO: begin
                    if (frame_done_c) begin
                        state         <= PLAYING;
                        frame_cnt     <= '0;
                        game_active_q <= 1'b1;
                    end
                end

                PLAYING: begin
                    if (gf.monster_killed) begin
                        kill_cnt <= kill_inc_c;
                        score_q  <= score_next_c;
                    end
                    // A hit outranks a level-clearing kill for the transition.
                    if (gf.player_hit) begin
                        lives_q       <= lives_dec_c;
                        state         <= (lives_dec_c == '0) ? GAME_OVER : PLAYER_DIED;
                        frame_cnt     <= '0;
                        game_active_q <= 1'b0;
                    end else if (kill_reach_c) begin
                        state         <= LEVEL_CLEAR;
                        frame_cnt     <= '0;
                        game_active_q <= 1'b0;
                    end
                end

                PLAYER_DIED: begin
                    if (frame_done_c) begin
                        frame_cnt <= '0;
                        if (kill_cnt >= KILL_W'(KILLS_PER_LEVEL)) begin
                            state         <= LEVEL_CLEAR;
                            game_active_q <= 1'b0;
                        end else begin
                            state            <= PLAYING;
                            game_active_q    <= 1'b1;
                            player_respawn_q <= 1'b1;
                        end
                    end
                end

                LEVEL_CLEAR: begin
                    if (frame_done_c) begin
                        frame_cnt     <= '0;
                        game_active_q <= 1'b0;
                        if (level_q == LEVEL_W'(MAX_LEVEL)) begin
                            state <= GAME_WON;
                        end else begin
                            level_q       <= level_q + LEVEL_W'(1);
                            kill_cnt      <= '0;
                            state         <= LEVEL_INTRO;
                            level_start_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    frame_cnt     <= '0;
                    game_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign gf.game_phase     = state;
    assign gf.game_active    = game_active_q;
    assign gf.level_start    = level_start_q;
    assign gf.player_respawn = player_respawn_q;
    assign gf.level          = level_q;
    assign gf.lives          = lives_q;
    assign gf.score          = score_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with an expected-state scoreboard.
module tb_game_flow_controller;

    logic clk;
    logic resetN;

    game_flow_controller_if #(.SCORE_WIDTH(16)) gf ();

    game_flow_controller dut (
        .clk    (clk),
        .resetN (resetN),
        .gf     (gf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ph;
        logic        act;
        logic [3:0]  lvl;
        logic [2:0]  liv;
        logic [15:0] sc;
    } obs_t;

    obs_t  sb_exp[$];
    string sb_tag[$];

    int checks   = 0;
    int failures = 0;

    // Running strobe totals; the stimulus takes snapshots for windowed counts.
    int ls_total = 0;
    int rs_total = 0;
    always @(posedge clk) begin
        if (gf.level_start)    ls_total++;
        if (gf.player_respawn) rs_total++;
    end

    task automatic expect_out(input string tag, input logic [2:0] ph, input logic act,
                              input logic [3:0] lvl, input logic [2:0] liv,
                              input logic [15:0] sc);
        obs_t e;
        e.ph = ph; e.act = act; e.lvl = lvl; e.liv = liv; e.sc = sc;
        sb_exp.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic check_out();
        obs_t  got;
        obs_t  exp;
        string tag;
        got = {gf.game_phase, gf.game_active, gf.level, gf.lives, gf.score};
        checks++;
        if (sb_exp.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", got);
        end else begin
            exp = sb_exp.pop_front();
            tag = sb_tag.pop_front();
            assert (got === exp) else begin
                failures++;
                $error("FAIL %s observed phase=%0d act=%0d lvl=%0d lives=%0d score=%0d expected phase=%0d act=%0d lvl=%0d lives=%0d score=%0d",
                       tag, got.ph, got.act, got.lvl, got.liv, got.sc,
                       exp.ph, exp.act, exp.lvl, exp.liv, exp.sc);
            end
        end
    endtask

    task automatic check_cnt(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One-cycle input pulse launched and retired on falling edges.
    task automatic pulse(input logic hit, input logic kill, input logic sof,
                         input logic mk, input logic [8:0] key);
        @(negedge clk);
        gf.player_hit     = hit;
        gf.monster_killed = kill;
        gf.startOfFrame   = sof;
        gf.make           = mk;
        gf.keyCode        = key;
        @(negedge clk);
        gf.player_hit     = 1'b0;
        gf.monster_killed = 1'b0;
        gf.startOfFrame   = 1'b0;
        gf.make           = 1'b0;
        gf.keyCode        = 9'h000;
    endtask

    task automatic frames(input int n);
        repeat (n) pulse(1'b0, 1'b0, 1'b1, 1'b0, 9'h000);
    endtask

    task automatic kills(input int n);
        repeat (n) pulse(1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
    endtask

    task automatic hit();
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    task automatic press(input logic [8:0] key);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, key);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int ls_base;
    int rs_base;

    initial begin
        resetN            = 1'b0;
        gf.startOfFrame   = 1'b0;
        gf.keyCode        = 9'h000;
        gf.make           = 1'b0;
        gf.player_hit     = 1'b0;
        gf.monster_killed = 1'b0;
        idle(3);
        resetN = 1'b1;
        idle(1);

        expect_out("reset_state", 3'd0, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();

        // Hits and kills in IDLE are ignored; a non-start key is ignored.
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
        expect_out("idle_hit_kill", 3'd0, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();
        press(9'h029);
        expect_out("idle_wrong_key", 3'd0, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 9'h05A);
        expect_out("key_without_make", 3'd0, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();

        // Start: LEVEL_INTRO with a single level_start strobe.
        ls_base = ls_total;
        press(9'h05A);
        expect_out("start_intro", 3'd1, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
        expect_out("intro_hit_kill", 3'd1, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();
        frames(119);
        expect_out("intro_119", 3'd1, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();
        check_cnt("start_level_start_pulses", ls_total - ls_base, 1);
        frames(1);
        expect_out("intro_done", 3'd2, 1'b1, 4'd1, 3'd3, 16'd0);
        check_out();

        // Level 1: sixteen kills clear it.
        kills(15);
        expect_out("kills_15", 3'd2, 1'b1, 4'd1, 3'd3, 16'd150);
        check_out();
        kills(1);
        expect_out("kills_16_clear", 3'd4, 1'b0, 4'd1, 3'd3, 16'd160);
        check_out();
        ls_base = ls_total;
        frames(119);
        expect_out("clear_119", 3'd4, 1'b0, 4'd1, 3'd3, 16'd160);
        check_out();
        frames(1);
        expect_out("level2_intro", 3'd1, 1'b0, 4'd2, 3'd3, 16'd160);
        check_out();
        idle(1);
        check_cnt("level2_level_start_pulses", ls_total - ls_base, 1);

        // Level 2: hit, respawn, then a simultaneous hit+kill on the 16th kill.
        frames(120);
        hit();
        expect_out("hit_died", 3'd3, 1'b0, 4'd2, 3'd2, 16'd160);
        check_out();
        rs_base = rs_total;
        frames(89);
        expect_out("died_89", 3'd3, 1'b0, 4'd2, 3'd2, 16'd160);
        check_out();
        frames(1);
        expect_out("respawn_play", 3'd2, 1'b1, 4'd2, 3'd2, 16'd160);
        check_out();
        idle(2);
        check_cnt("respawn_pulses", rs_total - rs_base, 1);
        kills(15);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 9'h000);
        expect_out("hit_and_kill", 3'd3, 1'b0, 4'd2, 3'd1, 16'd320);
        check_out();
        rs_base = rs_total;
        frames(90);
        expect_out("died_to_clear", 3'd4, 1'b0, 4'd2, 3'd1, 16'd320);
        check_out();
        idle(2);
        check_cnt("no_respawn_when_cleared", rs_total - rs_base, 0);
        frames(120);
        expect_out("level3_intro", 3'd1, 1'b0, 4'd3, 3'd1, 16'd320);
        check_out();

        // Levels 3 and 4, then the win.
        frames(120);
        kills(16);
        frames(120);
        expect_out("level4_intro", 3'd1, 1'b0, 4'd4, 3'd1, 16'd480);
        check_out();
        frames(120);
        kills(16);
        expect_out("level4_clear", 3'd4, 1'b0, 4'd4, 3'd1, 16'd640);
        check_out();
        frames(120);
        expect_out("game_won", 3'd6, 1'b0, 4'd4, 3'd1, 16'd640);
        check_out();
        pulse(1'b1, 1'b1, 1'b1, 1'b0, 9'h000);
        expect_out("won_hold", 3'd6, 1'b0, 4'd4, 3'd1, 16'd640);
        check_out();
        ls_base = ls_total;
        press(9'h05A);
        expect_out("restart_from_won", 3'd1, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();
        idle(1);
        check_cnt("restart_level_start_pulses", ls_total - ls_base, 1);

        // Lose all lives.
        frames(120);
        hit();
        expect_out("hit1", 3'd3, 1'b0, 4'd1, 3'd2, 16'd0);
        check_out();
        frames(90);
        hit();
        expect_out("hit2", 3'd3, 1'b0, 4'd1, 3'd1, 16'd0);
        check_out();
        frames(90);
        hit();
        expect_out("game_over", 3'd5, 1'b0, 4'd1, 3'd0, 16'd0);
        check_out();
        press(9'h029);
        expect_out("over_wrong_key", 3'd5, 1'b0, 4'd1, 3'd0, 16'd0);
        check_out();

        // Restart, score 50, then asynchronous reset between clock edges.
        press(9'h05A);
        frames(120);
        kills(5);
        expect_out("score_50", 3'd2, 1'b1, 4'd1, 3'd3, 16'd50);
        check_out();
        #2 resetN = 1'b0;
        #1;
        expect_out("async_reset", 3'd0, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();
        check_cnt("async_reset_strobes", int'(gf.level_start) + int'(gf.player_respawn), 0);
        idle(2);
        ls_base = ls_total;
        rs_base = rs_total;
        resetN = 1'b1;
        idle(3);
        expect_out("after_release", 3'd0, 1'b0, 4'd1, 3'd3, 16'd0);
        check_out();
        check_cnt("release_no_pulses", (ls_total - ls_base) + (rs_total - rs_base), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
